// File: rtl/mem_port_master_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_port_master_pkg : shared sizing and response entry layout
// Rev 1.0
// -----------------------------------------------------------------------------
package mem_port_master_pkg;

  localparam int ADDR_WORDS = 65536;
  localparam int RSP_DEPTH  = 3;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_master_rsp_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rsp_fifo : synchronous load-response FIFO with occupancy count
// Rev 1.0
// -----------------------------------------------------------------------------
module rsp_fifo
  import mem_port_master_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  rsp_entry_t    din_i,
  input  logic          pop_i,
  output rsp_entry_t    dout_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t        mem_q [DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     count_q;
  logic              w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = pop_i && (count_q != '0);

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= f_next(wr_q);
      end
      if (w_pop) begin
        rd_q <= f_next(rd_q);
      end
      case ({push_i, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_master.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_port_master : valid/ready request port driving a single-port RAM
// Rev 1.0
// -----------------------------------------------------------------------------
module mem_port_master #(
  parameter int ADDR_WORDS = mem_port_master_pkg::ADDR_WORDS,
  parameter int RSP_DEPTH  = mem_port_master_pkg::RSP_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_dout,
  output logic        err_sticky
);

  import mem_port_master_pkg::*;

  localparam int        CW           = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] C_DEPTH    = (CW + 1)'(RSP_DEPTH);
  localparam logic [32:0] C_ADDR_LIM = 33'(ADDR_WORDS);

  logic          pend_q, pend_d;
  logic          pend_err_q, pend_err_d;
  logic          err_q, err_d;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_in_range;
  logic          w_acc;
  logic          w_pop;
  rsp_entry_t    w_push_entry;
  rsp_entry_t    w_head;

  // Occupancy counts the in-flight load so the FIFO can never overflow.
  assign w_occ      = (CW + 1)'(w_count) + (CW + 1)'(pend_q);
  assign w_in_range = {1'b0, req_addr} < C_ADDR_LIM;
  assign req_ready  = !rst && (w_occ < C_DEPTH);
  assign w_acc      = req_valid && req_ready;

  assign mem_en   = w_acc && w_in_range;
  assign mem_we   = mem_en && req_we;
  assign mem_addr = mem_en ? req_addr  : '0;
  assign mem_di   = mem_en ? req_wdata : '0;

  assign pend_d     = w_acc && !req_we;
  assign pend_err_d = w_acc && !req_we && !w_in_range;
  assign err_d      = err_q || (w_acc && !w_in_range);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
      err_q      <= err_d;
    end
  end

  assign w_push_entry.err  = pend_err_q;
  assign w_push_entry.data = pend_err_q ? 32'h0 : mem_dout;

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pend_q),
    .din_i   (w_push_entry),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .count_o (w_count)
  );

  assign rsp_valid  = !rst && (w_count != '0);
  assign w_pop      = rsp_valid && rsp_ready;
  assign rsp_rdata  = rst ? 32'h0 : w_head.data;
  assign rsp_err    = !rst && w_head.err;
  assign err_sticky = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_master.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mem_port_master : scoreboard bench with a read-first RAM model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_mem_port_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_dout;
  logic        err_sticky;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   pop_cyc[$];
  logic [31:0] ram [logic [31:0]];
  logic [31:0] tbl [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  mem_port_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_di     (mem_di),
    .mem_dout   (mem_dout),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first RAM: output register gets the old word before the write lands.
  initial mem_dout = 32'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
      if (mem_we) ram[mem_addr] = mem_di;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && mem_en) chk("mem_en_in_rst", 1, 0);
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else if (rsp_ready) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_err", rsp_err, e.err);
        pop_cyc.push_back(cyc);
      end else begin
        chk("hold_rdata", rsp_rdata, exp_q[0].data);
        chk("hold_err", rsp_err, exp_q[0].err);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, output int stalls);
    logic inr;
    exp_t e;
    inr    = (addr < 32'd65536);
    stalls = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready) begin
        chk("mem_en", mem_en, inr);
        if (inr) begin
          chk("mem_we", mem_we, we);
          chk("mem_addr", mem_addr, addr);
          if (we) chk("mem_di", mem_di, wd);
        end else begin
          chk("mem_we_oor", mem_we, 0);
        end
        if (!we) begin
          e.err  = ee;
          e.data = ed;
          exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk); #1;
    end
    chk("req_timeout", 1, 0);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int acc;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd5;
    req_wdata = 32'hFFFFFFFF;
    rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_di", mem_di, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) issue(1'b1, 32'(i), tbl[i], 0, 0, st);
    issue(1'b1, 32'd5, 32'h1234ABCD, 0, 0, st);
    issue(1'b1, 32'd7, 32'h0BADF00D, 0, 0, st);

    // Store/load round trip and two-edge latency.
    issue(1'b0, 32'd5, 0, 32'h1234ABCD, 1'b0, st);
    @(negedge clk);
    chk("lat_edge1_valid", rsp_valid, 0);
    @(negedge clk);
    chk("lat_edge2_valid", rsp_valid, 1);
    @(posedge clk); #1;
    drain("lat_drained");

    pop_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'(i), 0, tbl[i], 1'b0, st);
      chk("b2b_stalls", st, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_npops", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_consecutive", pop_cyc[i] - pop_cyc[0], i);
    end

    // Backpressure: only three loads fit before req_ready drops.
    rsp_ready = 1'b0;
    acc       = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int n = 0; n < 6; n++) begin
      exp_t e;
      req_addr = 32'(acc % 4);
      @(negedge clk);
      if (req_ready) begin
        e.err  = 1'b0;
        e.data = tbl[acc % 4];
        exp_q.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 3);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("bp_drained");
    @(negedge clk);
    chk("bp_ready_back", req_ready, 1);
    @(posedge clk); #1;

    // Out-of-range load then store.
    chk("err_before_oor", err_sticky, 0);
    issue(1'b0, 32'h00010000, 0, 32'h0, 1'b1, st);
    @(negedge clk);
    chk("err_sticky_set", err_sticky, 1);
    @(posedge clk); #1;
    drain("oor_ld_drained");
    issue(1'b1, 32'h00010000, 32'h5555AAAA, 0, 0, st);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("oor_st_no_rsp", rsp_valid, 0);
    chk("oor_st_ram", ram.exists(32'h00010000), 0);
    chk("err_sticky_hold", err_sticky, 1);
    @(posedge clk); #1;

    // Store immediately followed by load of the same word.
    issue(1'b1, 32'd7, 32'hCAFEF00D, 0, 0, st);
    issue(1'b0, 32'd7, 0, 32'hCAFEF00D, 1'b0, st);
    drain("raw_drained");

    // Mid-operation reset with two queued responses and one pending.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 32'(i), 0, tbl[i], 1'b0, st);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd3;
    @(negedge clk);
    chk("mrst_mem_en", mem_en, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_req_ready", req_ready, 0);
    chk("mrst_rsp_rdata", rsp_rdata, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_err_sticky", err_sticky, 0);
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
